seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Iterative 32-bit restoring divider for the multdiv unit. Consumes one quotient bit per clock.
- Drives its own 5-bit iteration down-counter: loads it on start, decrements it once per iteration, and finishes on the terminal count.
- Sits between the ALU-side issue logic (ctrl_div pulse, operands) and writeback (result, ready and exception handshake).

Parameters:
- WIDTH, 32, operand and result width; must equal 2^CNT_W.
- CNT_W, 5, iteration counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ctrl_div  in  1  start pulse; sampled only in IDLE.
- dividend  in  WIDTH  operand A; sampled with ctrl_div.
- divisor  in  WIDTH  operand B; sampled with ctrl_div.
- quotient  out  WIDTH  result; valid while result_rdy is high.
- remainder  out  WIDTH  remainder; valid while result_rdy is high.
- result_rdy  out  1  one-cycle completion pulse.
- exception  out  1  divide-by-zero flag; valid with result_rdy.
- busy  out  1  high from the cycle after start until the cycle result_rdy is asserted, inclusive.

Behaviour:
- Reset values: quotient=0, remainder=0, result_rdy=0, exception=0, busy=0, state=IDLE, counter=0. Outputs hold 0 after reset until the first result.
- Reset in any state aborts the operation. The next cycle is IDLE with all outputs 0. Reset has priority over ctrl_div.
- States: IDLE, ITER, FIX, DONE.
- IDLE:
  - ctrl_div=1 and divisor!=0: latch |A| and |B| (signed build) or A and B; record sign bits; load counter with WIDTH-1; go to ITER.
  - ctrl_div=1 and divisor==0: go to DONE with zero flag set.
- ITER, each cycle:
  - {R,Q} shifts left 1 (R is WIDTH+1 bits).
  - trial = R - B. If trial >= 0: R = trial and Q[0] = 1. Otherwise Q[0] = 0 and R is kept (restoring).
  - Counter decrements. On the cycle the counter reads 0, go to FIX. Exactly WIDTH iterations run.
- FIX:
  - Quotient sign = signA xor signB; remainder sign = signA. Negate where required, two's complement, truncated to WIDTH.
  - Go to DONE.
- DONE:
  - result_rdy=1 for exactly one cycle, quotient and remainder driven; then go to IDLE.
  - Divide-by-zero: exception=1, quotient=0, remainder=0.
- Latency, with ctrl_div sampled at edge E0:
  - Normal: result_rdy is high in the cycle following edge E0+WIDTH+2, i.e. 34 cycles for WIDTH=32.
  - Divide-by-zero: result_rdy high after E0+1.
- quotient and remainder hold their last value after DONE until the next DONE or reset.
- ctrl_div while busy or in DONE is ignored; no queueing.
- ctrl_div in the IDLE cycle directly following DONE is accepted (back-to-back issue).
- Overflow: INT_MIN / -1 (signed build) yields 0x80000000 with remainder 0 and no exception, because two's-complement negation wraps.
- Operand inputs may change freely after the start cycle.

Optional Feature:
- Macro DIV_SIGNED_EN.
- Defined: operands are two's complement. Magnitudes are taken in IDLE and the sign fix-up is applied in FIX.
- Undefined: unsigned division. FIX is a pass-through cycle with no negation, so latency is unchanged. The INT_MIN case does not apply.

Decomposition:
- Package multdiv_pkg:
  - constant WIDTH=32 and constant CNT_W=5.
  - state enum typedef {IDLE, ITER, FIX, DONE}.
  - constant LATENCY_NORM=WIDTH+2.
- One sub-module, div_iter_ctr: CNT_W-bit down-counter.
  - Synchronous load of a start value, decrement enable, terminal flag at 0.
  - The counter saturates at 0 and does not wrap to 31.

Test Plan:
- 100 / 7 -> 34 cycles later: quotient=14, remainder=2, result_rdy one-cycle pulse, exception=0, busy low afterwards.
- 5 / 0 -> result_rdy and exception high in the cycle after edge E0+1; quotient=0, remainder=0.
- Signed build: -100 / 7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- Unsigned build: 0xFFFFFFFF / 2 -> quotient=0x7FFFFFFF, remainder=1.
- ctrl_div pulsed at cycle 10 of an operation with different operands -> ignored; the first result is unchanged. ctrl_div the cycle after DONE -> accepted, second result correct.
- reset asserted mid-ITER (cycle 15) -> next cycle: busy=0, outputs 0, no result_rdy. A fresh 9 / 3 then gives quotient=3, remainder=0.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared constants and state encoding for the multdiv sequential divider.
package multdiv_pkg;

  localparam int WIDTH        = 32;
  localparam int CNT_W        = 5;
  localparam int LATENCY_NORM = WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } div_state_e;

endpackage

// File: rtl/seq_divider_if.sv
// Issue/writeback bundle between the ALU-side issue logic and the sequential divider.
interface seq_divider_if #(
  parameter int WIDTH = 32
);

  logic             ctrl_div;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             result_rdy;
  logic             exception;
  logic             busy;

  modport master (
    output ctrl_div, dividend, divisor,
    input  quotient, remainder, result_rdy, exception, busy
  );

  modport slave (
    input  ctrl_div, dividend, divisor,
    output quotient, remainder, result_rdy, exception, busy
  );

endinterface

// File: rtl/seq_divider_iter_ctr.sv
// Iteration down-counter for the divider: load, decrement, terminal flag at zero.
module div_iter_ctr #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             term
);

  logic [CNT_W-1:0] cnt;

  // Decrement stops at zero so a stray enable can never wrap back to the top.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign term = (cnt == '0);

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands; otherwise the divide is unsigned.
module seq_divider
  import multdiv_pkg::*;
#(
  parameter int WIDTH = multdiv_pkg::WIDTH,
  parameter int CNT_W = multdiv_pkg::CNT_W
) (
  input  logic           clk,
  input  logic           reset,
  seq_divider_if.slave   bus
);

  localparam logic signed [WIDTH+1:0] TRIAL_ZERO = '0;

  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? neg2c(x) : x;
  endfunction

  div_state_e state, state_nxt;

  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dsr_r;
  logic             dz_r;

  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             rdy_q;
  logic             exc_q;

  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_term;
  logic             dsr_zero;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]          r_sh;
  logic signed [WIDTH+1:0] trial;
  logic                    trial_neg;

`ifdef DIV_SIGNED_EN
  logic sign_q;
  logic sign_r;

  assign a_mag = mag(bus.dividend);
  assign b_mag = mag(bus.divisor);
`else
  assign a_mag = bus.dividend;
  assign b_mag = bus.divisor;
`endif

  assign dsr_zero = (bus.divisor == '0);

  div_iter_ctr #(
    .CNT_W (CNT_W)
  ) u_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (CNT_W'(WIDTH - 1)),
    .dec      (cnt_dec),
    .term     (cnt_term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ctrl_div) begin
          if (dsr_zero) begin
            state_nxt = DONE;
          end else begin
            state_nxt = ITER;
            cnt_load  = 1'b1;
          end
        end
      end
      ITER: begin
        cnt_dec = 1'b1;
        if (cnt_term) state_nxt = FIX;
      end
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift {R,Q} left and try the subtraction; the remainder never exceeds
  // the divisor, so only the shifted value needs the extra bit.
  assign r_sh      = {rem_r, quo_r[WIDTH-1]};
  assign trial     = $signed({1'b0, r_sh}) - $signed({2'b00, dsr_r});
  assign trial_neg = (trial < TRIAL_ZERO);

  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (bus.ctrl_div) begin
          rem_r <= '0;
          quo_r <= a_mag;
          dsr_r <= b_mag;
          dz_r  <= dsr_zero;
`ifdef DIV_SIGNED_EN
          sign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          sign_r <= bus.dividend[WIDTH-1];
`endif
        end
      end
      ITER: begin
        rem_r <= trial_neg ? r_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_r <= {quo_r[WIDTH-2:0], ~trial_neg};
      end
      FIX: begin
`ifdef DIV_SIGNED_EN
        if (sign_q) quo_r <= neg2c(quo_r);
        if (sign_r) rem_r <= neg2c(rem_r);
`endif
      end
      default: ;
    endcase
  end

  // Results are registered out of DONE, so the pulse lands in the following IDLE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      quotient_q  <= '0;
      remainder_q <= '0;
      rdy_q       <= 1'b0;
      exc_q       <= 1'b0;
    end else begin
      rdy_q <= (state == DONE);
      exc_q <= (state == DONE) && dz_r;
      if (state == DONE) begin
        quotient_q  <= dz_r ? '0 : quo_r;
        remainder_q <= dz_r ? '0 : rem_r;
      end
    end
  end

  assign bus.quotient   = quotient_q;
  assign bus.remainder  = remainder_q;
  assign bus.result_rdy = rdy_q;
  assign bus.exception  = exc_q;
  assign bus.busy       = (state != IDLE) || rdy_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (signed vectors when DIV_SIGNED_EN is defined).
module tb_seq_divider;
  import multdiv_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  seq_divider_if #(.WIDTH(32)) bus ();

  seq_divider dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one divide from just after a rising edge; returns in the result_rdy cycle.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int pulse_at, input int exp_lat,
                         input logic [31:0] exp_q, input logic [31:0] exp_r,
                         input logic exp_exc);
    int n;
    bus.ctrl_div = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.ctrl_div = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    chk({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.result_rdy && n < 60) begin
      if (n == pulse_at) begin
        bus.ctrl_div = 1'b1;
        bus.dividend = 32'd77;
        bus.divisor  = 32'd3;
      end else begin
        bus.ctrl_div = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.ctrl_div = 1'b0;
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_quotient"}, bus.quotient, exp_q);
    chk({tag, "_remainder"}, bus.remainder, exp_r);
    chk({tag, "_exception"}, 32'(bus.exception), 32'(exp_exc));
    chk({tag, "_busy_rdy"}, 32'(bus.busy), 32'd1);
  endtask

  task automatic check_after(input string tag, input logic [31:0] exp_q, input logic [31:0] exp_r);
    @(posedge clk); #1;
    chk({tag, "_rdy_pulse"}, 32'(bus.result_rdy), 32'd0);
    chk({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
    chk({tag, "_exc_low"}, 32'(bus.exception), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_hold_q"}, bus.quotient, exp_q);
    chk({tag, "_hold_r"}, bus.remainder, exp_r);
  endtask

  initial begin
    int rdy_seen;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.ctrl_div = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_quotient", bus.quotient, 32'd0);
    chk("rst_remainder", bus.remainder, 32'd0);
    chk("rst_rdy", 32'(bus.result_rdy), 32'd0);
    chk("rst_exc", 32'(bus.exception), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);

    run_div("d100_7", 32'd100, 32'd7, -1, LATENCY_NORM, 32'd14, 32'd2, 1'b0);
    check_after("d100_7", 32'd14, 32'd2);

    run_div("d5_0", 32'd5, 32'd0, -1, 1, 32'd0, 32'd0, 1'b1);
    check_after("d5_0", 32'd0, 32'd0);

    run_div("d7_9", 32'd7, 32'd9, -1, LATENCY_NORM, 32'd0, 32'd7, 1'b0);
    check_after("d7_9", 32'd0, 32'd7);

`ifdef DIV_SIGNED_EN
    run_div("dm100_7", 32'hFFFF_FF9C, 32'd7, -1, LATENCY_NORM, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    check_after("dm100_7", 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    run_div("dmin_m1", 32'h8000_0000, 32'hFFFF_FFFF, -1, LATENCY_NORM, 32'h8000_0000, 32'd0, 1'b0);
    check_after("dmin_m1", 32'h8000_0000, 32'd0);
`else
    run_div("dmax_2", 32'hFFFF_FFFF, 32'd2, -1, LATENCY_NORM, 32'h7FFF_FFFF, 32'd1, 1'b0);
    check_after("dmax_2", 32'h7FFF_FFFF, 32'd1);
    run_div("dmax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, LATENCY_NORM, 32'd1, 32'd0, 1'b0);
    check_after("dmax_max", 32'd1, 32'd0);
`endif

    // Stray start mid-operation is ignored, then a start in the result cycle is taken.
    run_div("ign", 32'd1000, 32'd10, 10, LATENCY_NORM, 32'd100, 32'd0, 1'b0);
    run_div("b2b", 32'd45, 32'd6, -1, LATENCY_NORM, 32'd7, 32'd3, 1'b0);
    check_after("b2b", 32'd7, 32'd3);

    // Abort mid-iteration.
    bus.ctrl_div = 1'b1;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd3;
    @(posedge clk); #1;
    bus.ctrl_div = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_rdy", 32'(bus.result_rdy), 32'd0);
    chk("abort_quotient", bus.quotient, 32'd0);
    chk("abort_remainder", bus.remainder, 32'd0);
    chk("abort_exc", 32'(bus.exception), 32'd0);
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.result_rdy || bus.busy) rdy_seen++;
    end
    chk("abort_quiet", 32'(rdy_seen), 32'd0);

    run_div("d9_3", 32'd9, 32'd3, -1, LATENCY_NORM, 32'd3, 32'd0, 1'b0);
    check_after("d9_3", 32'd3, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
